servo_pwm_array: RTL and testbench

Parametrised N-channel servo driver. One shared microsecond timebase and frame counter drive N independent channels. Each channel keeps a saturating pulse-width position register, stepped once per PWM frame by a 2-bit direction command, and generates a glitch-free servo pulse from that register. It sits between the tracking FSM, which supplies the direction commands, and the servo pins. It replaces the per-motor driver pairs with a single block that has configurable channel count, limits and step size.

---
 rtl/servo_pkg.sv | 30 +++
 rtl/servo_channel.sv | 59 +++++
 rtl/servo_pwm_array.sv | 103 ++++++++++
 tb/tb_servo_pwm_array.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================
// servo_pkg : shared direction codes and saturating step helper
// Rev 1.0
// ============================================================
package servo_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b10;

  // Wide enough for any supported PW_W (<= 32) plus one guard bit.
  localparam int SAT_W = 33;

  function automatic logic [SAT_W-1:0] sat_step(
    input logic [SAT_W-1:0] pos,
    input logic [1:0]       dir,
    input logic [SAT_W-1:0] step,
    input logic [SAT_W-1:0] lo,
    input logic [SAT_W-1:0] hi
  );
    case (dir)
      DIR_CW:  return ((pos + step) > hi) ? hi : (pos + step);
      DIR_CCW: return (pos < (lo + step)) ? lo : (pos - step);
      default: return pos;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_channel.sv
`default_nettype none
// ============================================================
// servo_channel : one saturating position register and PWM output
// Rev 1.0
// ============================================================
module servo_channel
  import servo_pkg::*;
#(
  parameter int PW_W    = 16,
  parameter int CNT_W   = 15,
  parameter int PW_MIN  = 500,
  parameter int PW_MAX  = 2500,
  parameter int PW_INIT = 1500,
  parameter int STEP_US = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             frame_start_i,
  input  logic             en_i,
  input  logic             armed_i,
  input  logic [1:0]       dir_i,
  input  logic [CNT_W-1:0] frame_cnt_i,
  output logic             servo_o,
  output logic [PW_W-1:0]  pos_o,
  output logic             gen_en_o
);

  localparam logic [PW_W-1:0] C_PW_MIN  = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] C_PW_MAX  = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0] C_PW_INIT = PW_W'(PW_INIT);

  logic [PW_W-1:0] pos_q, pos_d;
  logic            servo_q, servo_d;

  always_comb begin
    pos_d = pos_q;
    if (frame_start_i && en_i) begin
      pos_d = PW_W'(sat_step(SAT_W'(pos_q), dir_i, SAT_W'(STEP_US),
                             SAT_W'(PW_MIN), SAT_W'(PW_MAX)));
    end
    servo_d = armed_i && (SAT_W'(frame_cnt_i) < SAT_W'(pos_q));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q   <= C_PW_INIT;
      servo_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      servo_q <= servo_d;
    end
  end

  assign servo_o  = servo_q;
  assign pos_o    = pos_q;
  assign gen_en_o = (pos_q > C_PW_MIN) && (pos_q < C_PW_MAX);

endmodule
`default_nettype wire

// File: rtl/servo_pwm_array.sv
`default_nettype none
// ============================================================
// servo_pwm_array : shared us timebase / frame counter driving N servo channels
// Rev 1.0
// ============================================================
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int CLK_DIV  = 100,
  parameter int FRAME_US = 20000,
  parameter int PW_W     = 16,
  parameter int PW_MIN   = 500,
  parameter int PW_MAX   = 2500,
  parameter int PW_INIT  = 1500,
  parameter int STEP_US  = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic [2*N_CH-1:0]      DIR,
  output logic [N_CH-1:0]        SERVO,
  output logic [N_CH*PW_W-1:0]   servo_position,
  output logic [N_CH-1:0]        general_enable,
  output logic                   frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_FRAME_LAST = CNT_W'(FRAME_US - 1);

  if (!((PW_MIN <= PW_INIT) && (PW_INIT <= PW_MAX) && (PW_MAX < FRAME_US))) begin : g_bad_limits
    $fatal(1, "servo_pwm_array: require PW_MIN <= PW_INIT <= PW_MAX < FRAME_US");
  end
  if ((PW_W > 32) || ((longint'(PW_MAX) + longint'(STEP_US)) >= (longint'(1) << PW_W))) begin : g_bad_width
    $fatal(1, "servo_pwm_array: require PW_MAX + STEP_US < 2**PW_W and PW_W <= 32");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $fatal(1, "servo_pwm_array: require CLK_DIV >= 1");
  end

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             armed_q, armed_d;
  logic             tick;
  logic             frame_wrap;

  always_comb begin
    tick        = (presc_q == C_DIV_LAST);
    frame_wrap  = tick && (frame_cnt_q == C_FRAME_LAST);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    frame_cnt_d = frame_cnt_q;
    if (tick) begin
      frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
    end
    // Arming only at a frame boundary keeps a late enable from emitting a runt pulse.
    armed_d = armed_q;
    if (!EN) begin
      armed_d = 1'b0;
    end else if (frame_wrap) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q     <= '0;
      frame_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      frame_cnt_q <= frame_cnt_d;
      armed_q     <= armed_d;
    end
  end

  assign frame_start = frame_wrap;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_channel #(
      .PW_W    (PW_W),
      .CNT_W   (CNT_W),
      .PW_MIN  (PW_MIN),
      .PW_MAX  (PW_MAX),
      .PW_INIT (PW_INIT),
      .STEP_US (STEP_US)
    ) u_ch (
      .clk_i         (CLK),
      .rst_i         (RST),
      .frame_start_i (frame_wrap),
      .en_i          (EN),
      .armed_i       (armed_q),
      .dir_i         (DIR[2*i +: 2]),
      .frame_cnt_i   (frame_cnt_q),
      .servo_o       (SERVO[i]),
      .pos_o         (servo_position[PW_W*i +: PW_W]),
      .gen_en_o      (general_enable[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_array.sv
`default_nettype none
// ============================================================
// tb_servo_pwm_array : frame-level scoreboard bench for servo_pwm_array
// Rev 1.0
// ============================================================
module tb_servo_pwm_array;

  localparam int C_DIV   = 2;
  localparam int C_FRAME = 100;
  localparam int C_MIN   = 10;
  localparam int C_MAX   = 30;
  localparam int C_INIT  = 20;
  localparam int C_STEP  = 5;
  localparam int C_PW_W  = 16;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [3:0]  DIR;
  logic [1:0]  SERVO;
  logic [31:0] servo_position;
  logic [1:0]  general_enable;
  logic        frame_start;

  servo_pwm_array #(
    .N_CH(2), .CLK_DIV(C_DIV), .FRAME_US(C_FRAME), .PW_W(C_PW_W),
    .PW_MIN(C_MIN), .PW_MAX(C_MAX), .PW_INIT(C_INIT), .STEP_US(C_STEP)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .SERVO(SERVO),
    .servo_position(servo_position), .general_enable(general_enable),
    .frame_start(frame_start)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One entry per frame: what the frame that ends at the next frame_start must show.
  typedef struct {
    int pos0;
    int pos1;
    int hi0;
    int hi1;
    int ge;
    int per;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_pos [2];
  bit   m_arm;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_step(input int pos, input logic [1:0] d);
    if (d == 2'b01) return (pos + C_STEP > C_MAX) ? C_MAX : pos + C_STEP;
    if (d == 2'b10) return (pos - C_STEP < C_MIN) ? C_MIN : pos - C_STEP;
    return pos;
  endfunction

  function automatic int in_range(input int p);
    return ((p > C_MIN) && (p < C_MAX)) ? 1 : 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Entered at the negedge on which the previous frame_start is visible.
  // At the first negedge of the frame: EN=en_a, DIR=dir_mid; msw negedges later:
  // EN=en_b, DIR=dir, which are the values sampled at the closing frame_start.
  task automatic run_frame(input logic [3:0] dir_mid, input logic [3:0] dir,
                           input logic en_a, input int msw, input logic en_b);
    exp_t e;
    int   cut;
    bit   done;
    @(negedge CLK);
    EN  = en_a;
    DIR = dir_mid;
    // SERVO still shows one more high cycle after armed clears (registered output).
    cut = !m_arm ? 0 : (!en_a ? 1 : (!en_b ? msw + 1 : 100000));
    e.pos0 = m_pos[0];
    e.pos1 = m_pos[1];
    e.hi0  = imin(cut, m_pos[0] * C_DIV);
    e.hi1  = imin(cut, m_pos[1] * C_DIV);
    e.ge   = in_range(m_pos[0]) | (in_range(m_pos[1]) << 1);
    e.per  = C_DIV * C_FRAME;
    sb_q.push_back(e);
    repeat (msw) @(negedge CLK);
    EN  = en_b;
    DIR = dir;
    done = 1'b0;
    for (int i = 0; i < 3 * C_DIV * C_FRAME && !done; i++) begin
      @(negedge CLK);
      if (frame_start) done = 1'b1;
    end
    if (!done) chk("fs_timeout", 0, 1);
    if (en_b) begin
      m_pos[0] = model_step(m_pos[0], dir[1:0]);
      m_pos[1] = model_step(m_pos[1], dir[3:2]);
      m_arm    = 1'b1;
    end else begin
      m_arm = 1'b0;
    end
  endtask

  // Monitor: accumulates SERVO high cycles per frame and checks at each frame_start.
  int   mon_ncnt;
  int   mon_last;
  int   mon_h0;
  int   mon_h1;
  exp_t mon_e;

  initial begin
    mon_ncnt = 0; mon_last = 0; mon_h0 = 0; mon_h1 = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        mon_ncnt = 0; mon_last = 0; mon_h0 = 0; mon_h1 = 0;
      end else begin
        mon_ncnt++;
        mon_h0 += int'(SERVO[0]);
        mon_h1 += int'(SERVO[1]);
        if (frame_start) begin
          chk("sb_avail", int'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("period", mon_ncnt + 1 - mon_last, mon_e.per);
            chk("hi0", mon_h0, mon_e.hi0);
            chk("hi1", mon_h1, mon_e.hi1);
            chk("pos0", int'(servo_position[15:0]), mon_e.pos0);
            chk("pos1", int'(servo_position[31:16]), mon_e.pos1);
            chk("gen_en", int'(general_enable), mon_e.ge);
          end
          mon_last = mon_ncnt + 1;
          mon_h0 = 0;
          mon_h1 = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    EN  = 1'b1;
    DIR = 4'b0000;
    repeat (3) @(negedge CLK);
    chk("rst_servo", int'(SERVO), 0);
    chk("rst_pos0", int'(servo_position[15:0]), C_INIT);
    chk("rst_pos1", int'(servo_position[31:16]), C_INIT);
    chk("rst_gen_en", int'(general_enable), 3);
    chk("rst_fs", int'(frame_start), 0);
    m_pos[0] = C_INIT;
    m_pos[1] = C_INIT;
    m_arm    = 1'b0;
    #1 RST = 1'b0;

    run_frame(4'b0000, 4'b0000, 1'b1, 50, 1'b1);  // first frame: not armed
    run_frame(4'b0000, 4'b1001, 1'b1, 50, 1'b1);  // full 40-cycle pulses
    run_frame(4'b1001, 4'b1001, 1'b1, 50, 1'b1);  // ch0 cw, ch1 ccw
    run_frame(4'b1001, 4'b1001, 1'b1, 50, 1'b1);  // reach the limits
    run_frame(4'b0110, 4'b0000, 1'b1, 50, 1'b1);  // saturated; DIR toggled mid-frame only
    run_frame(4'b0000, 4'b1111, 1'b1, 50, 1'b1);  // DIR=11 at frame_start holds
    run_frame(4'b0000, 4'b0110, 1'b1, 50, 1'b1);  // step back inside the limits
    run_frame(4'b0101, 4'b0101, 1'b1, 20, 1'b0);  // EN dropped at frame cycle 10, cw held
    run_frame(4'b0101, 4'b0000, 1'b0, 60, 1'b1);  // EN raised mid-frame: no pulse
    run_frame(4'b0000, 4'b0000, 1'b1, 50, 1'b1);  // full pulse resumes

    // Reset in the middle of an active pulse.
    @(negedge CLK);
    repeat (10) @(negedge CLK);
    chk("servo_pre_rst", int'(SERVO), 3);
    #1 RST = 1'b1;
    #1;
    chk("servo_async_rst", int'(SERVO), 0);
    chk("pos0_async_rst", int'(servo_position[15:0]), C_INIT);
    chk("pos1_async_rst", int'(servo_position[31:16]), C_INIT);
    chk("gen_en_async_rst", int'(general_enable), 3);
    sb_q.delete();
    m_pos[0] = C_INIT;
    m_pos[1] = C_INIT;
    m_arm    = 1'b0;
    repeat (3) @(negedge CLK);
    #1 RST = 1'b0;

    run_frame(4'b0000, 4'b0000, 1'b1, 50, 1'b1);  // 200 cycles to first frame_start
    run_frame(4'b0000, 4'b0000, 1'b1, 50, 1'b1);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
